deserializer: RTL
=================

# deserializer

Receive-side counterpart of the serializer: it accepts one D-bit lane word per `high_speed_clock` cycle and reassembles S consecutive words into one D*S-bit frame. Frame boundaries come from a training pattern: the block searches the incoming word stream for `TRAIN_PATTERN`, locks to it, then emits a frame with a one-cycle valid strobe every S cycles. Slot 0 (first word received) lands in bits [D-1:0], matching the serializer's slot ordering.

## Interface
- `D`, 8, lane word width in bits.
- `S`, 8, words per frame (deserialization ratio). Legal range: S >= 2; S need not be a power of two.
- `TRAIN_PATTERN`, 64'hFEDC_BA98_7654_3210, D*S-bit alignment frame. Must be non-periodic at word granularity.

Ports (reset is synchronous, active-high; clock is `high_speed_clock`):
- `high_speed_clock` in 1: clock for every register.
- `reset` in 1: synchronous, active-high.
- `align_req` in 1: one-cycle request to drop lock and restart the search.
- `data_in` in D: lane word, sampled on every rising edge.
- `data_out` out D*S: last assembled frame. Holds its value between strobes.
- `data_valid` out 1: one-cycle pulse when `data_out` is updated.
- `aligned` out 1: high while in LOCKED.
- `pattern_seen` out 1: pulses with `data_valid` when the emitted frame equals `TRAIN_PATTERN`.

## Operation
- Window register `win` (D*S bits) shifts on every cycle in every state:
  - `win <= {data_in, win[D*S-1:D]}`.
  - The newest word enters at the top; the oldest word is at [D-1:0].
- Counters:
  - `fill` counts words shifted in since entering SEARCH, saturating at S (width $clog2(S+1)).
  - `slot` is the word index in LOCKED, range 0..S-1 (width $clog2(S), minimum 1).
- States: SEARCH, LOCKED. Reset enters SEARCH.
- SEARCH:
  - `fill` increments, saturating at S. The compare is enabled only when `fill == S`, so a zeroed window can never false-match.
  - When `fill == S` and `win == TRAIN_PATTERN`: go to LOCKED, set `slot <= 0`.
  - The word sampled on the next edge is slot 0.
  - `data_valid` stays 0 throughout SEARCH.
- LOCKED:
  - `slot` increments every cycle and wraps from S-1 to 0.
  - On an edge where `slot == S-1`:
    - `data_out <= {data_in, win[D*S-1:D]}` (the complete frame including the current word);
    - `data_valid <= 1`;
    - `pattern_seen <= (that value == TRAIN_PATTERN)`.
  - On every other edge, `data_valid` and `pattern_seen` are 0.
- `align_req`:
  - In any state, the next state is SEARCH, with `fill <= 0`, `slot <= 0` and `aligned <= 0`.
  - If `align_req` and a match occur on the same edge, `align_req` wins.
  - If `align_req` arrives on an edge where `slot == S-1`, no frame is emitted.
- Lock is held indefinitely. There is no automatic loss-of-lock; system firmware uses `pattern_seen` or data checks and asserts `align_req`.
- `reset` has priority over everything, including mid-frame:
  - `win`, `data_out`, `fill` and `slot` go to 0;
  - `data_valid`, `pattern_seen` and `aligned` go to 0;
  - state goes to SEARCH.

## Timing
- Reset values of all outputs are 0.
- Registered outputs only; there are no combinational paths from input to output.
- The earliest match occurs S edges after reset deasserts. `aligned` rises on the edge that registers the match.
- Frame latency: the slot S-1 word is sampled at edge k, and `data_out`/`data_valid` are valid after edge k (0 extra cycles). From the slot 0 word to the strobe is S-1 cycles.
- In LOCKED, `data_valid` has a period of exactly S cycles. The first strobe comes S edges after the match edge.
- Shifting of `win` is continuous and never stalls. There is no backpressure, and the consumer must accept every strobe.

## Test plan
- Reset, then drive the words 10,32,54,76,98,BA,DC,FE repeatedly, with the first word after reset release. The required response:
  - `aligned` rises after the 8th word;
  - `data_valid` pulses every 8 cycles;
  - `data_out` = 64'hFEDC_BA98_7654_3210;
  - `pattern_seen` = 1 on each strobe.
- Same stream, preceded by 3 junk words (00,AA,55) → lock occurs 3 cycles later, and the frames are still 64'hFEDC_BA98_7654_3210 (boundary correctly found).
- After lock, send the frame 11..88 (slot 0 = 11) → `data_out` = 64'h8877_6655_4433_2211 and `pattern_seen` = 0.
- Assert `align_req` while locked, mid-frame at slot 4 → `aligned` goes to 0, no strobe occurs for that frame, and the block relocks only after a full pattern is seen again.
- Reset asserted while locked, at slot 6 → all outputs are 0 on the next cycle, and no strobe occurs until a new match.
- Stream all-zero words after reset with `TRAIN_PATTERN` = 0 (parameter override) → no match before 8 words have been shifted in; lock occurs exactly at `fill == 8`.

Source files
------------

// File: rtl/deserializer.sv
// Lane deserializer: reassembles S D-bit words into one frame after locking
// onto a training pattern found in the incoming word stream.
module deserializer #(
    parameter int unsigned    D             = 8,
    parameter int unsigned    S             = 8,
    parameter logic [D*S-1:0] TRAIN_PATTERN = 64'hFEDC_BA98_7654_3210
) (
    input  logic             high_speed_clock,
    input  logic             reset,
    input  logic             align_req,
    input  logic [D-1:0]     data_in,
    output logic [D*S-1:0]   data_out,
    output logic             data_valid,
    output logic             aligned,
    output logic             pattern_seen
);

    localparam int unsigned W  = D * S;
    localparam int unsigned FW = $clog2(S + 1);
    localparam int unsigned SW = (S > 2) ? $clog2(S) : 1;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    win_q, win_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [W-1:0]    data_out_q, data_out_d;
    logic            data_valid_q, data_valid_d;
    logic            aligned_q, aligned_d;
    logic            pattern_seen_q, pattern_seen_d;

    // Next-state and output logic. Matching and frame capture both look at the
    // window including the word sampled on this edge, so the word after a
    // match edge is slot 0 and a strobe edge carries the complete frame.
    always_comb begin
        win_d          = {data_in, win_q[W-1:D]};
        state_d        = state_q;
        fill_d         = fill_q;
        slot_d         = slot_q;
        data_out_d     = data_out_q;
        data_valid_d   = 1'b0;
        pattern_seen_d = 1'b0;
        aligned_d      = aligned_q;

        if (align_req) begin
            state_d   = SEARCH;
            fill_d    = FW'(0);
            slot_d    = SW'(0);
            aligned_d = 1'b0;
        end else begin
            case (state_q)
                SEARCH: begin
                    aligned_d = 1'b0;
                    if (fill_q != FW'(S)) begin
                        fill_d = fill_q + FW'(1);
                    end
                    // Gate on a full window so a cleared window never matches.
                    if ((fill_d == FW'(S)) && (win_d == TRAIN_PATTERN)) begin
                        state_d   = LOCKED;
                        slot_d    = SW'(0);
                        aligned_d = 1'b1;
                    end
                end
                LOCKED: begin
                    aligned_d = 1'b1;
                    if (slot_q == SW'(S - 1)) begin
                        slot_d         = SW'(0);
                        data_out_d     = win_d;
                        data_valid_d   = 1'b1;
                        pattern_seen_d = (win_d == TRAIN_PATTERN);
                    end else begin
                        slot_d = slot_q + SW'(1);
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

    // State and output registers; synchronous reset overrides everything.
    always_ff @(posedge high_speed_clock) begin
        if (reset) begin
            state_q        <= SEARCH;
            win_q          <= '0;
            fill_q         <= '0;
            slot_q         <= '0;
            data_out_q     <= '0;
            data_valid_q   <= 1'b0;
            aligned_q      <= 1'b0;
            pattern_seen_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            win_q          <= win_d;
            fill_q         <= fill_d;
            slot_q         <= slot_d;
            data_out_q     <= data_out_d;
            data_valid_q   <= data_valid_d;
            aligned_q      <= aligned_d;
            pattern_seen_q <= pattern_seen_d;
        end
    end

    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign aligned      = aligned_q;
    assign pattern_seen = pattern_seen_q;

endmodule
